// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit: one shift-add or shift-subtract per clock.
// Division by zero and signed overflow finish straight from IDLE; flush aborts with no writeback.
module muldiv_unit #(
  parameter int dataWidth    = 32,
  parameter int AddressWidth = $clog2(dataWidth)
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [2:0]              funct3,
  input  logic [AddressWidth-1:0] rd,
  input  logic [dataWidth-1:0]    opA,
  input  logic [dataWidth-1:0]    opB,
  input  logic                    flush,
  output logic                    busy,
  output logic                    done,
  output logic                    RFwrite,
  output logic [AddressWidth-1:0] RegW,
  output logic [dataWidth-1:0]    dataW
);

  localparam int CW = $clog2(dataWidth) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             op_q;
  logic                   sign_a, sign_b;
  logic [dataWidth-1:0]   hi, lo, opnd;
  logic [CW-1:0]          cnt;

  // operand decode in IDLE
  logic                   a_signed, b_signed, neg_a, neg_b;
  logic [dataWidth-1:0]   abs_a, abs_b;
  logic                   div_zero, div_ovf, special;
  logic [dataWidth-1:0]   special_res;

  // iteration and sign-fix datapath
  logic [dataWidth:0]     mul_sum;
  logic [dataWidth:0]     div_shift, div_diff;
  logic                   div_ge;
  logic [2*dataWidth-1:0] prod, prod_s;
  logic [dataWidth-1:0]   quot_fix, rem_fix, fix_res;

  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    neg_a    = a_signed && opA[dataWidth-1];
    neg_b    = b_signed && opB[dataWidth-1];
    abs_a    = neg_a ? -opA : opA;
    abs_b    = neg_b ? -opB : opB;

    div_zero = funct3[2] && (opB == '0);
    div_ovf  = funct3[2] && !funct3[0] && (opB == '1) &&
               (opA == {1'b1, {(dataWidth-1){1'b0}}});
    special  = div_zero || div_ovf;
    if (div_zero) special_res = funct3[1] ? opA : '1;
    else          special_res = funct3[1] ? '0 : opA;
  end

  always_comb begin
    mul_sum   = {1'b0, hi} + {1'b0, opnd};
    div_shift = {hi, lo[dataWidth-1]};
    div_diff  = div_shift - {1'b0, opnd};
    // the remainder stays below the divisor, so the borrow bit alone decides
    div_ge    = !div_diff[dataWidth];

    prod     = {hi, lo};
    prod_s   = (sign_a ^ sign_b) ? -prod : prod;
    quot_fix = (sign_a ^ sign_b) ? -lo : lo;
    rem_fix  = sign_a ? -hi : hi;

    case (op_q)
      3'b000:                 fix_res = prod_s[dataWidth-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_s[2*dataWidth-1:dataWidth];
      3'b100, 3'b101:         fix_res = quot_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = special ? DONE : CALC;
      CALC: if (cnt == CW'(1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    RFwrite = 1'b0;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    RFwrite = done && (RegW != '0);
  end

  // hi:lo holds the product (multiply) or remainder:quotient (divide)
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      cnt    <= '0;
      RegW   <= '0;
      dataW  <= '0;
    end else if (!flush) begin
      case (state_q)
        IDLE: if (start) begin
          op_q   <= funct3;
          RegW   <= rd;
          sign_a <= neg_a;
          sign_b <= neg_b;
          hi     <= '0;
          lo     <= abs_a;
          opnd   <= abs_b;
          cnt    <= CW'(dataWidth);
          if (special) dataW <= special_res;
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (!op_q[2]) begin
            if (lo[0]) {hi, lo} <= {mul_sum, lo[dataWidth-1:1]};
            else       {hi, lo} <= {1'b0, hi, lo[dataWidth-1:1]};
          end else begin
            hi <= div_ge ? div_diff[dataWidth-1:0] : div_shift[dataWidth-1:0];
            lo <= {lo[dataWidth-2:0], div_ge};
          end
        end
        FIX: dataW <= fix_res;
        default: ;
      endcase
    end
  end

endmodule
